deserializador_serie: RTL and testbench

- Downstream stage of the 4-bit shift register: consumes its serial output S_OUT, one bit per valid strobe, and rebuilds parallel words of W bits.
- Bit order follows the upstream shift direction: left shift emits MSB first, right shift emits LSB first.
- Completed words move into a one-entry holding register and are presented through a valid/ready handshake to the next consumer.
- Assembly of the next word continues while the held word waits.

---
 rtl/deserializador_serie_pkg.sv | 15 +
 rtl/deserializador_serie_buffer_salida.sv | 60 ++++++
 rtl/deserializador_serie.sv | 88 ++++++++
 tb/tb_deserializador_serie.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/deserializador_serie_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: holding-register
// state encoding, bit-order constants and the default word width.
package deserializador_serie_pkg;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    localparam logic DIR_IZQ = 1'b0;   // MSB first (upstream left shift)
    localparam logic DIR_DER = 1'b1;   // LSB first (upstream right shift)

    localparam int W_DEF = 4;

endpackage

// File: rtl/deserializador_serie_buffer_salida.sv
// One-entry holding register presenting completed words through valid/ready,
// with sticky overflow when a word completes while the held one is still pending.
module buffer_salida
    import deserializador_serie_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] word_in,
    input  logic         word_done,
    input  logic         clr,
    input  logic         data_ready,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    output logic         overflow
);

    estado_t        state_reg;
    logic [W-1:0]   data_reg;
    logic           overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= VACIO;
            data_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                VACIO: begin
                    if (word_done) begin
                        data_reg  <= word_in;
                        state_reg <= LLENO;
                    end
                end
                LLENO: begin
                    // A hand-off in the same cycle as a completion frees the slot
                    // for the new word, so there is neither bubble nor drop.
                    if (word_done && data_ready) begin
                        data_reg <= word_in;
                    end else if (data_ready) begin
                        state_reg <= VACIO;
                    end
                end
                default: state_reg <= VACIO;
            endcase

            if (clr) begin
                overflow_reg <= 1'b0;
            end else if (state_reg == LLENO && word_done && !data_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign data_out   = data_reg;
    assign data_valid = (state_reg == LLENO);
    assign overflow   = overflow_reg;

endmodule

// File: rtl/deserializador_serie.sv
// Rebuilds W-bit words from a strobed serial stream; bit order is latched on the
// first bit of each word and completed words are handed to buffer_salida.
module deserializador_serie
    import deserializador_serie_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          S_IN,
    input  logic          S_VALID,
    input  logic          DIR,
    input  logic          CLR,
    input  logic          data_ready,
    output logic [W-1:0]  data_out,
    output logic          data_valid,
    output logic [CW-1:0] bit_count,
    output logic          overflow
);

    logic [W-1:0]  acc_reg;
    logic [W-1:0]  msb_next;
    logic [W-1:0]  lsb_next;
    logic [W-1:0]  acc_next;
    logic [CW-1:0] count_reg;
    logic          dir_reg;
    logic          dir_eff;
    logic          accept;
    logic          word_done;

    assign accept    = S_VALID && !CLR;
    // On the first bit the live DIR applies; afterwards the latched copy does.
    assign dir_eff   = (count_reg == '0) ? DIR : dir_reg;
    assign word_done = accept && (count_reg == CW'(W - 1));

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_acc
            if (gi == 0) begin : g_lo
                assign msb_next[gi] = S_IN;
            end else begin : g_lo_sh
                assign msb_next[gi] = acc_reg[gi-1];
            end
            if (gi == W - 1) begin : g_hi
                assign lsb_next[gi] = S_IN;
            end else begin : g_hi_sh
                assign lsb_next[gi] = acc_reg[gi+1];
            end
        end
    endgenerate

    assign acc_next = (dir_eff == DIR_IZQ) ? msb_next : lsb_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
        end else if (CLR) begin
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (S_VALID) begin
            acc_reg <= acc_next;
            if (count_reg == '0) begin
                dir_reg <= DIR;
            end
            count_reg <= word_done ? '0 : count_reg + CW'(1);
        end
    end

    buffer_salida #(
        .W (W)
    ) u_buffer_salida (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (acc_next),
        .word_done  (word_done),
        .clr        (CLR),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overflow   (overflow)
    );

    assign bit_count = count_reg;

endmodule

// File: tb/tb_deserializador_serie.sv
// Randomized and directed checks of the deserializer against a word-level model
// that collects bits in an array and builds each word arithmetically.
module tb_deserializador_serie;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          S_IN = 1'b0;
    logic          S_VALID = 1'b0;
    logic          DIR = 1'b0;
    logic          CLR = 1'b0;
    logic          data_ready = 1'b0;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic [CW-1:0] bit_count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    deserializador_serie #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .S_IN       (S_IN),
        .S_VALID    (S_VALID),
        .DIR        (DIR),
        .CLR        (CLR),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bit_count  (bit_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int  m_bits [W];
    int  m_n     = 0;
    int  m_dir   = 0;
    int  m_out   = 0;
    int  m_valid = 0;
    int  m_ovf   = 0;

    function automatic int build_word(input int dir);
        int w = 0;
        for (int i = 0; i < W; i++) begin
            if (dir == 0) w += m_bits[i] * (1 << (W - 1 - i));
            else          w += m_bits[i] * (1 << i);
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_dir = 0; m_out = 0; m_valid = 0; m_ovf = 0;
        end else begin
            int done;
            int word;
            done = 0;
            word = 0;
            if (!CLR && S_VALID) begin
                if (m_n == 0) m_dir = int'(DIR);
                m_bits[m_n] = int'(S_IN);
                m_n++;
                if (m_n == W) begin
                    word = build_word(m_dir);
                    done = 1;
                    m_n  = 0;
                end
            end else if (CLR) begin
                m_n = 0;
            end
            if (m_valid == 1) begin
                if (done == 1) begin
                    if (data_ready) m_out = word;
                    else            m_ovf = 1;
                end else if (data_ready) begin
                    m_valid = 0;
                end
            end else if (done == 1) begin
                m_out   = word;
                m_valid = 1;
            end
            if (CLR) m_ovf = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model data_out",   int'(data_out),   m_out);
        check("model data_valid", int'(data_valid), m_valid);
        check("model bit_count",  int'(bit_count),  m_n);
        check("model overflow",   int'(overflow),   m_ovf);
    end

    // One clock with the given inputs; returns after the following negedge.
    task automatic cyc(input logic v, input logic b, input logic d,
                       input logic c, input logic r);
        S_VALID = v; S_IN = b; DIR = d; CLR = c; data_ready = r;
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic d, input logic r_last);
        for (int i = 0; i < W; i++) begin
            logic bitv;
            bitv = (d == 1'b0) ? w[W-1-i] : w[i];
            cyc(1'b1, bitv, d, 1'b0, (i == W - 1) ? r_last : 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // MSB first 1,0,1,1
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("msb valid before last bit", int'(data_valid), 0);
        cyc(1, 1, 0, 0, 0);
        check("msb data_out", int'(data_out), 'b1011);
        check("msb data_valid", int'(data_valid), 1);
        check("msb bit_count", int'(bit_count), 0);
        $display("txn msb word: data_out=%b valid=%0d", data_out, data_valid);

        cyc(0, 0, 0, 0, 1);
        check("consume valid", int'(data_valid), 0);
        check("consume data_out kept", int'(data_out), 'b1011);

        // LSB first with DIR dropping after the first bit
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("lsb latched data_out", int'(data_out), 'b1101);
        $display("txn lsb word: data_out=%b valid=%0d", data_out, data_valid);

        // Back-to-back: completion with data_ready while LLENO
        send_word(4'b0110, 1'b0, 1'b1);
        check("b2b data_out", int'(data_out), 'b0110);
        check("b2b data_valid", int'(data_valid), 1);
        check("b2b overflow", int'(overflow), 0);
        $display("txn back-to-back: data_out=%b ovf=%0d", data_out, overflow);

        // Overflow
        cyc(0, 0, 0, 0, 1);
        send_word(4'b1011, 1'b0, 1'b0);
        send_word(4'b0001, 1'b0, 1'b0);
        check("ovf data_out held", int'(data_out), 'b1011);
        check("ovf flag", int'(overflow), 1);
        cyc(0, 0, 0, 1, 0);
        check("clr overflow", int'(overflow), 0);
        check("clr keeps valid", int'(data_valid), 1);
        $display("txn overflow+clr: data_out=%b ovf=%0d valid=%0d", data_out, overflow, data_valid);

        // Gaps and CLR priority
        cyc(1, 1, 0, 0, 0);
        check("gap count 1", int'(bit_count), 1);
        cyc(0, 1, 1, 0, 0);
        check("gap count hold a", int'(bit_count), 1);
        cyc(0, 0, 1, 0, 0);
        check("gap count hold b", int'(bit_count), 1);
        cyc(1, 0, 0, 0, 0);
        check("gap count 2", int'(bit_count), 2);
        cyc(1, 1, 0, 1, 0);
        check("clr priority count", int'(bit_count), 0);
        $display("txn gaps+clr: bit_count=%0d", bit_count);

        // Asynchronous reset mid-word with a held word present
        cyc(1, 1, 0, 0, 0);
        S_VALID = 1'b1; S_IN = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset data_out", int'(data_out), 0);
        check("areset data_valid", int'(data_valid), 0);
        check("areset bit_count", int'(bit_count), 0);
        check("areset overflow", int'(overflow), 0);
        $display("txn async reset: out=%b valid=%0d count=%0d ovf=%0d",
                 data_out, data_valid, bit_count, overflow);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic v, b, d, c, r;
            v = ($urandom_range(0, 99) < 60);
            b = 1'($urandom);
            d = 1'($urandom);
            c = ($urandom_range(0, 99) < 4);
            r = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 999) < 3) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            cyc(v, b, d, c, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
